uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the peripheral register interface, stores up to DEPTH of them, and launches them one at a time into the transmitter through its `tx_start`/`tx_data`/`busy` handshake. `tx_data` is held stable for the whole frame, because the transmitter samples data bits live throughout transmission.

---
 rtl/uart_tx_fifo_pkg.sv | 20 ++
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 88 ++++++++
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
// Shared constants and small helpers for the UART transmit byte buffer.
// Ports: none (package).
package uart_tx_fifo_pkg;

  // Width of one UART data byte.
  localparam int DATA_W = 8;

  // Default transmit buffer depth in bytes.
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [DATA_W-1:0] data_t;

  // True when depth is a power of two and at least 2. Pointer wrap relies on
  // that.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Launch handshake between the transmit buffer and the UART transmitter.
// Handshake: tx_start is a single-cycle pulse and is only issued while
// tx_busy is low. tx_data is valid from the tx_start cycle and held stable
// until the transmitter drops tx_busy at the end of the frame, and it keeps
// that value until the next launch.
// Signals:
//   tx_start  buffer -> transmitter  one-cycle launch pulse
//   tx_data   buffer -> transmitter  byte in flight
//   tx_busy   transmitter -> buffer  transmitter busy with a frame
// Modports: master = buffer side, slave = transmitter side.
interface uart_tx_fifo_if;
  import uart_tx_fifo_pkg::*;

  logic  tx_start;
  data_t tx_data;
  logic  tx_busy;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy
  );

endinterface : uart_tx_fifo_if

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo
// Single-clock circular buffer with naturally wrapping pointers. It is shared
// by the UART TX and RX paths.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        enqueue wr_data_i (ignored when full or flushing)
//   wr_data_i     word to enqueue
//   pop_i         dequeue the head word (ignored when empty)
//   flush_i       synchronous clear of pointers and count; beats push
//   rd_data_o     head word (mem[rd_ptr]), valid while !empty_o
//   full_o        count == DEPTH
//   empty_o       count == 0
//   count_o       number of stored words
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          wr_ok;
  logic          rd_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem[rd_ptr_q];

  // A write while full is dropped even if a pop happens in the same cycle,
  // because full is taken from the registered count. A flush discards the
  // incoming word.
  assign wr_ok = push_i && !full_o && !flush_i;
  assign rd_ok = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage has no reset. Only the slots between the pointers are ever
  // read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule : sync_fifo

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit-side byte buffer feeding the UART transmitter. Bytes written by the
// register interface are queued in sync_fifo. A launcher FSM pops one byte at
// a time and hands it to the transmitter. The byte stays on tx_data for the
// whole frame.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_en          push wr_data this cycle
//   wr_data        byte to enqueue
//   flush          clear queued (not yet launched) bytes
//   clr_overflow   clear the sticky overflow flag
//   full, empty    queue occupancy flags
//   count          queued bytes, excluding the byte in flight
//   overflow       sticky: a write was dropped because the queue was full
//   tx_idle        queue empty and launcher idle
//   tx_if          launch handshake to the transmitter (master side)
//   dbg_state_o    launcher FSM state, for observation only
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  data_t                 wr_data,
  input  logic                  flush,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  tx_idle,
  uart_tx_fifo_if.master        tx_if,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_ACTIVE    = 2'd3
  } state_e;

  state_e state_q;
  logic   tx_start_q;
  data_t  tx_data_q;
  logic   overflow_q, overflow_d;
  logic   pop;
  data_t  head_data;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .flush_i   (flush),
    .rd_data_o (head_data),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  // Only the IDLE state launches, and never into a busy transmitter. A flush
  // in the same cycle does not cancel this pop, so the head byte still goes
  // out.
  assign pop = (state_q == S_IDLE) && !empty && !tx_if.tx_busy;

  // Set wins over clear. A write discarded by a flush does not count as an
  // overflow.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow)                 overflow_d = 1'b0;
    if (wr_en && full && !flush)      overflow_d = 1'b1;
  end

  // Launcher: IDLE -> LAUNCH (pulse) -> WAIT_BUSY (transmitter picks up the
  // frame) -> ACTIVE (frame on the line) -> IDLE once busy drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q  <= head_data;
            tx_start_q <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_start_q <= 1'b0;
          state_q    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_if.tx_busy) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!tx_if.tx_busy) state_q <= S_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow       = overflow_q;
  assign tx_idle        = empty && (state_q == S_IDLE);
  assign tx_if.tx_start = tx_start_q;
  assign tx_if.tx_data  = tx_data_q;
  assign dbg_state_o    = state_q;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Bench for uart_tx_fifo. The reference model is a byte queue (exp_q) holding
// bytes that were accepted but not yet launched, plus an expected overflow
// bit. The transmitter model holds busy for frame_len cycles after each
// launch. The monitor pops exp_q on every tx_start and compares the
// occupancy flags, the overflow flag and tx_data every cycle.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          full, empty, overflow, tx_idle;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  uart_tx_fifo_if bus();

  logic hold_busy  = 1'b0;
  logic frame_busy = 1'b0;
  assign bus.tx_busy = hold_busy | frame_busy;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_idle      (tx_idle),
    .tx_if        (bus.master),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       ov_exp     = 1'b0;
  logic [7:0] data_exp   = 8'h00;
  int         frame_len  = 4;
  int         busy_cnt   = 0;
  int         cyc        = 0;
  int         launch_cyc = -1;
  int         launches   = 0;
  int         fall_cyc   = 0;
  logic       gap_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor + transmitter model ----------------
  initial begin : monitor
    logic busy_at_edge;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy_cnt    = 0;
        frame_busy  = 1'b0;
        data_exp    = 8'h00;
        gap_pending = 1'b0;
        continue;
      end
      busy_at_edge = bus.tx_busy;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          frame_busy  = 1'b0;
          fall_cyc    = cyc;
          gap_pending = (exp_q.size() > 0) && !hold_busy;
        end
      end
      if (bus.tx_start === 1'b1) begin
        check("start_while_busy", 32'(busy_at_edge), 32'd0);
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_start");
        end else begin
          b = exp_q.pop_front();
          check("launch_data", 32'(bus.tx_data), 32'(b));
          data_exp = b;
        end
        if (gap_pending) check("launch_gap", 32'(cyc - fall_cyc), 32'd2);
        gap_pending = 1'b0;
        launch_cyc  = cyc;
        launches++;
        busy_cnt    = frame_len;
        frame_busy  = 1'b1;
      end
      check("count",    32'(count),    32'(exp_q.size()));
      check("empty",    32'(empty),    32'(exp_q.size() == 0));
      check("full",     32'(full),     32'(exp_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(ov_exp));
      check("tx_data",  32'(bus.tx_data), 32'(data_exp));
      if (frame_busy) check("tx_idle_busy", 32'(tx_idle), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge. The model is updated
  // for the rising edge that follows.
  task automatic apply(input logic we, input logic [7:0] d, input logic fl, input logic clr);
    wr_en = we; wr_data = d; flush = fl; clr_overflow = clr;
    if (fl) exp_q.delete();
    else if (we) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else ov_exp = 1'b1;
    end
    if (clr && !(we && !fl && exp_q.size() == DEPTH && !(exp_q.size() < DEPTH) && 1'b0))
      ;
  endtask

  task automatic drive_cycle(input logic we, input logic [7:0] d, input logic fl, input logic clr);
    logic ov_set;
    @(negedge clk); #1;
    ov_set = we && !fl && (exp_q.size() == DEPTH);
    apply(we, d, fl, 1'b0);
    clr_overflow = clr;
    if (clr && !ov_set) ov_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    bit done = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !frame_busy) begin
        done = 1;
        break;
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    if (!done) flag_fail({name, "_drain_timeout"});
    idle(3);
    check({name, "_tx_idle"}, 32'(tx_idle), 32'd1);
  endtask

  task automatic pulse_reset(input string name);
    wr_en = 1'b0; flush = 1'b0; clr_overflow = 1'b0; hold_busy = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    ov_exp = 1'b0;
    #1;
    check({name, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({name, "_tx_data"},  32'(bus.tx_data),  32'h00);
    check({name, "_empty"},    32'(empty),        32'd1);
    check({name, "_full"},     32'(full),         32'd0);
    check({name, "_count"},    32'(count),        32'd0);
    check({name, "_overflow"}, 32'(overflow),     32'd0);
    check({name, "_tx_idle"},  32'(tx_idle),      32'd1);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int wr_cyc;
    int n_before;
    int written;
    logic [7:0] r;

    #2;
    pulse_reset("por");

    // Single byte into an idle transmitter.
    frame_len = 6;
    drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    wr_cyc = cyc;
    wait_drain(100, "single");
    check("single_latency", 32'(launch_cyc - wr_cyc), 32'd2);
    check("single_launches", 32'(launches), 32'd1);

    // Three back-to-back bytes with long frames. The launch gap is checked
    // by the monitor.
    frame_len = 100;
    drive_cycle(1'b1, 8'h01, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h02, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h03, 1'b0, 1'b0);
    wait_drain(600, "b2b");
    check("b2b_launches", 32'(launches), 32'd4);

    // Overfill while the transmitter is held busy.
    frame_len = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(1);
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_count",    32'(count),    32'(DEPTH));
    check("ovf_overflow", 32'(overflow), 32'd1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    n_before = launches;
    hold_busy = 1'b0;
    wait_drain(400, "ovf");
    check("ovf_launches", 32'(launches - n_before), 32'(DEPTH));

    // Flush while 8'h55 is in flight with five bytes queued.
    frame_len = 60;
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !frame_busy; i++) idle(1);
    if (!frame_busy) flag_fail("flush_no_launch");
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
    idle(1);
    check("flush_count_before", 32'(count), 32'd5);
    n_before = launches;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    check("flush_count_after", 32'(count), 32'd0);
    wait_drain(200, "flush");
    idle(10);
    check("flush_no_more_starts", 32'(launches - n_before), 32'd0);

    // Push and pop in the same cycle with four bytes queued.
    frame_len = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(1);
    check("pp_count_before", 32'(count), 32'd4);
    @(negedge clk); #1;
    hold_busy = 1'b0;
    apply(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(1);
    check("pp_count_same", 32'(count), 32'd4);

    // 40 random bytes with random pacing, crossing the pointer wrap.
    n_before = launches + exp_q.size();
    written = 0;
    for (int i = 0; i < 3000 && written < 40; i++) begin
      if ($urandom_range(0, 7) == 0) frame_len = $urandom_range(2, 6);
      if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
        r = 8'($urandom);
        drive_cycle(1'b1, r, 1'b0, 1'b0);
        written++;
      end else begin
        idle(1);
      end
    end
    check("wrap_written", 32'(written), 32'd40);
    wait_drain(800, "wrap");
    check("wrap_launches", 32'(launches - n_before), 32'd40);

    // Asynchronous reset in the middle of a frame with bytes still queued.
    frame_len = 50;
    drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h99, 1'b0, 1'b0);
    idle(8);
    if (!frame_busy) flag_fail("midrst_no_frame");
    @(posedge clk); #3;
    pulse_reset("midrst");
    n_before = launches;
    idle(10);
    check("midrst_no_starts", 32'(launches - n_before), 32'd0);

    // Recovery after reset.
    frame_len = 4;
    drive_cycle(1'b1, 8'h7E, 1'b0, 1'b0);
    wait_drain(100, "recover");
    check("recover_launches", 32'(launches - n_before), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Whole-run watchdog.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_uart_tx_fifo
